// File: rtl/dct1d_pkg.sv
// dct1d_pkg: shared constants, Q8 DCT-II coefficient ROM and saturation bounds for dct1d_q8
package dct1d_pkg;
  localparam int DCT_PTS = 8;
  localparam int FRAC_DEF = 8;
  localparam int COEF_W = FRAC_DEF + 1;
  localparam logic signed [COEF_W-1:0] COEF [DCT_PTS][DCT_PTS] = '{
    '{  9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91},
    '{ 9'sd126,  9'sd106,   9'sd71,   9'sd25,  -9'sd25,  -9'sd71, -9'sd106, -9'sd126},
    '{ 9'sd118,   9'sd49,  -9'sd49, -9'sd118, -9'sd118,  -9'sd49,   9'sd49,  9'sd118},
    '{ 9'sd106,  -9'sd25, -9'sd126,  -9'sd71,   9'sd71,  9'sd126,   9'sd25, -9'sd106},
    '{  9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91},
    '{  9'sd71, -9'sd126,   9'sd25,  9'sd106, -9'sd106,  -9'sd25,  9'sd126,  -9'sd71},
    '{  9'sd49, -9'sd118,  9'sd118,  -9'sd49,  -9'sd49,  9'sd118, -9'sd118,   9'sd49},
    '{  9'sd25,  -9'sd71,  9'sd106, -9'sd126,  9'sd126, -9'sd106,   9'sd71,  -9'sd25}
  };
  function automatic longint sat_hi(input int n);
    return (longint'(1) << (n - 1)) - 1;
  endfunction
  function automatic longint sat_lo(input int n);
    return -(longint'(1) << (n - 1));
  endfunction
endpackage

// File: rtl/dct1d_dot8.sv
// dct1d_dot8: combinational 8-term signed dot product, arithmetic shift by FRAC, saturate to N bits (rounds when DCT1D_ROUND_EN); ports x (8 packed lanes), row (coefficients), y (result)
module dct1d_dot8 import dct1d_pkg::*; #(
  parameter int N = 16,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [DCT_PTS*N-1:0]      x,
  input  logic signed [COEF_W-1:0]  row [DCT_PTS],
  output logic [N-1:0]              y
);
  localparam int PW = N + FRAC + 1;
  localparam int AW = N + FRAC + 4;
  localparam logic signed [AW-1:0] HI = AW'(sat_hi(N));
  localparam logic signed [AW-1:0] LO = AW'(sat_lo(N));
  logic signed [PW-1:0] p [DCT_PTS];
  logic signed [AW-1:0] acc, sh;
  always_comb begin
    acc = '0;
    for (int i = 0; i < DCT_PTS; i++) begin
      p[i] = $signed(x[N*i +: N]) * row[i];
      acc = acc + AW'(p[i]);
    end
`ifdef DCT1D_ROUND_EN
    sh = (acc + AW'(1 << (FRAC - 1))) >>> FRAC;
`else
    sh = acc >>> FRAC;
`endif
    y = sh > HI ? HI[N-1:0] : sh < LO ? LO[N-1:0] : sh[N-1:0];
  end
endmodule

// File: rtl/dct1d_q8.sv
// dct1d_q8: 8-point 1-D DCT-II, Q8 coefficients, one vector per clock, 1-cycle registered latency; ports clk, rst (async high), data_in/data_out (8 lanes of N bits, lane 0 LSB); macro DCT1D_ROUND_EN enables round-half-up
module dct1d_q8 import dct1d_pkg::*; #(
  parameter int N = 16,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DCT_PTS*N-1:0] data_in,
  output logic [DCT_PTS*N-1:0] data_out
);
  logic [DCT_PTS*N-1:0] d;
  for (genvar k = 0; k < DCT_PTS; k++) begin : g_row
    dct1d_dot8 #(.N(N), .FRAC(FRAC)) u_dot (
      .x(data_in),
      .row(COEF[k]),
      .y(d[N*k +: N])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) data_out <= '0;
    else data_out <= d;
endmodule

// File: tb/tb_dct1d_q8.sv
// tb_dct1d_q8: directed self-checking bench for dct1d_q8
module tb_dct1d_q8;
  logic clk = 0;
  logic rst = 0;
  logic [127:0] data_in = '0;
  logic [127:0] data_out;
  int checks = 0;
  int errors = 0;

  dct1d_q8 dut (.clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out));

  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input int a [8]);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(a[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [127:0] v, input logic [127:0] e);
    data_in = v;
    @(posedge clk);
    #1;
    chk(tag, data_out, e);
  endtask

  logic [127:0] imp, imp_x, cst, cst_x, rmp, zero;
  int r1;

  initial begin
    imp   = pk('{256, 0, 0, 0, 0, 0, 0, 0});
    imp_x = pk('{91, 126, 118, 106, 91, 71, 49, 25});
    cst   = pk('{100, 100, 100, 100, 100, 100, 100, 100});
    cst_x = pk('{284, 0, 0, 0, 0, 0, 0, 0});
    rmp   = pk('{104, 103, 104, 103, 103, 103, 102, 100});
    zero  = '0;
`ifdef DCT1D_ROUND_EN
    r1 = 3;
`else
    r1 = 2;
`endif
    #2 rst = 1;
    #1 chk("reset_async", data_out, zero);
    data_in = imp;
    @(posedge clk); #1;
    chk("reset_hold", data_out, zero);
    rst = 0;
    step("impulse", imp, imp_x);
    #2 rst = 1;
    #1 chk("midstream_reset_async", data_out, zero);
    @(posedge clk); #1;
    chk("midstream_reset_hold", data_out, zero);
    rst = 0;
    step("impulse_after_reset", imp, imp_x);
    step("constant", cst, cst_x);
    data_in = rmp;
    @(posedge clk); #1;
    chk("ramp_x0", {112'd0, data_out[15:0]}, 128'd292);
    chk("ramp_x1", {112'd0, data_out[31:16]}, {112'd0, 16'(r1)});
    step("sat_pos", pk('{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}),
         pk('{32767, 0, 0, 0, 0, 0, 0, 0}));
    step("sat_neg", pk('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}),
         pk('{-32768, 0, 0, 0, 0, 0, 0, 0}));
    step("b2b_impulse", imp, imp_x);
    step("b2b_constant", cst, cst_x);
    step("b2b_zero", zero, zero);
    step("neg_impulse", pk('{0, 0, 0, -256, 0, 0, 0, 0}),
         pk('{-91, -25, 118, 71, -91, -106, 49, 126}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
